dcmac_0_axis_pkt_mon_merge_sched: RTL

DCMAC_0_AXIS_PKT_MON_MERGE_SCHED -- requirements
Module: dcmac_0_axis_pkt_mon_merge_sched

---
 rtl/dcmac_0_axis_pkt_mon_merge_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dcmac_0_axis_pkt_mon_merge_sched.sv
// Packet-atomic round-robin scheduler for N_CH LBUS channels into a fixed-latency merge datapath.
// Grant is zero-latency, output tag lags the grant by MERGE_LAT cycles, and a requester waits until it is granted.
// Optional lock watchdog: define DCMAC_0_PKT_MON_MERGE_SCHED_WDOG_EN.
module dcmac_0_axis_pkt_mon_merge_sched #(
    parameter int N_CH      = 6,
    parameter int MERGE_LAT = 5,
    parameter int WDOG_CYC  = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_req,
    input  logic [N_CH-1:0] i_sop,
    input  logic [N_CH-1:0] i_eop,
    output logic [N_CH-1:0] o_gnt,
    output logic            o_sel_vld,
    output logic [2:0]      o_sel_id,
    output logic            o_out_vld,
    output logic [2:0]      o_out_id,
    output logic            o_proto_err,
    output logic [31:0]     o_pkt_cnt
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [2:0]      lock_id;
    logic [2:0]      rr_ptr;
    logic [N_CH-1:0] elig;
    logic [N_CH-1:0] lock_oh;
    logic            lock_req;
    logic            sel_sop;
    logic            sel_eop;
    logic            stray;
    logic            hi_found;
    logic            lo_found;
    logic [2:0]      hi_id;
    logic [2:0]      lo_id;
    logic [2:0]      sel_id;
    logic            sel_vld;
    logic            wdog_fire;

    logic [MERGE_LAT-1:0] vld_pipe;
    logic [2:0]           id_pipe [MERGE_LAT];

    function automatic logic [2:0] nxt(input logic [2:0] id);
        return (id == 3'(N_CH - 1)) ? 3'd0 : id + 3'd1;
    endfunction

    assign elig     = i_req & i_sop;
    assign lock_oh  = N_CH'(1) << lock_id;
    assign lock_req = |(i_req & lock_oh);
    assign stray    = (state == IDLE) && |(i_req & ~i_sop);

    // Descending scan: lo_id ends at the lowest eligible channel, hi_id at the lowest one >= rr_ptr.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = 3'd0;
        lo_id    = 3'd0;
        sel_vld  = 1'b0;
        sel_id   = 3'd0;
        if (state == IDLE) begin
            for (int c = N_CH - 1; c >= 0; c--) begin
                if (elig[c]) begin
                    lo_found = 1'b1;
                    lo_id    = 3'(c);
                    if (3'(c) >= rr_ptr) begin
                        hi_found = 1'b1;
                        hi_id    = 3'(c);
                    end
                end
            end
            sel_vld = hi_found | lo_found;
            sel_id  = hi_found ? hi_id : (lo_found ? lo_id : 3'd0);
        end else if (lock_req) begin
            sel_vld = 1'b1;
            sel_id  = lock_id;
        end
    end

    assign o_sel_vld = sel_vld;
    assign o_sel_id  = sel_id;
    assign o_gnt     = sel_vld ? (N_CH'(1) << sel_id) : '0;
    assign sel_sop   = |(o_gnt & i_sop);
    assign sel_eop   = |(o_gnt & i_eop);

`ifdef DCMAC_0_PKT_MON_MERGE_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wdog_cnt;

    assign wdog_fire = (state == LOCKED) && !lock_req && (wdog_cnt == WW'(WDOG_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if ((state == LOCKED) && !lock_req && !wdog_fire) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end else begin
            wdog_cnt <= '0;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lock_id     <= 3'd0;
            rr_ptr      <= 3'd0;
            o_pkt_cnt   <= 32'd0;
            o_proto_err <= 1'b0;
        end else begin
            o_proto_err <= 1'b0;
            if (sel_vld && sel_eop) begin
                o_pkt_cnt <= o_pkt_cnt + 32'd1;
            end
            case (state)
                IDLE: begin
                    o_proto_err <= stray;
                    if (sel_vld) begin
                        if (sel_eop) begin
                            rr_ptr <= nxt(sel_id);
                        end else begin
                            state   <= LOCKED;
                            lock_id <= sel_id;
                        end
                    end
                end
                LOCKED: begin
                    if (sel_vld) begin
                        o_proto_err <= sel_sop;
                        if (sel_eop) begin
                            state  <= IDLE;
                            rr_ptr <= nxt(lock_id);
                        end
                    end else if (wdog_fire) begin
                        // Abandon a stalled packet without counting it.
                        state       <= IDLE;
                        rr_ptr      <= nxt(lock_id);
                        o_proto_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < MERGE_LAT; i++) begin
                id_pipe[i] <= 3'd0;
            end
        end else begin
            vld_pipe[0] <= sel_vld;
            id_pipe[0]  <= sel_id;
            for (int i = 1; i < MERGE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    assign o_out_vld = vld_pipe[MERGE_LAT-1];
    assign o_out_id  = id_pipe[MERGE_LAT-1];

endmodule
